// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states
// and the request legality check applied when a request is captured.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Illegal size, conflicting load/store, or an address that is not
    // naturally aligned for the access size.
    function automatic logic req_error(
        input logic       load,
        input logic       store,
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic err;
        err = 1'b0;
        if (size == SZ_ILLEGAL)
            err = 1'b1;
        if (load && store)
            err = 1'b1;
        if (size == SZ_HALF && addr_lo[0])
            err = 1'b1;
        if (size == SZ_WORD && addr_lo != 2'b00)
            err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane handling: load extract/extend and store merge into
// the old memory word. Purely combinational.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = rdata[7:0];
        case (addr_lo)
            2'b00:   byte_val = rdata[7:0];
            2'b01:   byte_val = rdata[15:8];
            2'b10:   byte_val = rdata[23:16];
            default: byte_val = rdata[31:24];
        endcase
        half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_val[7]}}, byte_val};
            SZ_HALF: load_data = {{16{~is_unsigned & half_val[15]}}, half_val};
            default: load_data = rdata;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the old word survives.
    always_comb begin
        merge_data = rdata;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'b00:   merge_data[7:0]   = wdata[7:0];
                    2'b01:   merge_data[15:8]  = wdata[7:0];
                    2'b10:   merge_data[23:16] = wdata[7:0];
                    default: merge_data[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1])
                    merge_data[31:16] = wdata[15:0];
                else
                    merge_data[15:0]  = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-only data memory: sub-word accesses,
// read-modify-write stores, alignment checking and a one-cycle response.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              dmem_MemRead,
    output logic              dmem_MemWrite,
    output logic [ADDR_W-1:0] dmem_Address,
    output logic [DATA_W-1:0] dmem_Write_data,
    input  logic [DATA_W-1:0] dmem_Read_data
);

    state_t            state;
    state_t            state_next;
    logic              load_q;
    logic              store_q;
    logic              uns_q;
    logic              err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;

    mau_lane_align u_lane_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .addr_lo     (addr_q[1:0]),
        .rdata       (dmem_Read_data),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        load_q  <= req_load;
                        store_q <= req_store;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= req_error(req_load, req_store, req_size, req_addr[1:0]);
                    end
                end
                ST_ACCESS: begin
                    // A legal request never has both load and store set.
                    if (!err_q && load_q)
                        rdata_q <= load_data;
                    if (!err_q && store_q && size_q != SZ_WORD)
                        merge_q <= merge_data;
                end
                default: ;
            endcase
        end
    end

    // Strobes depend only on registered state, so reset removes them at once.
    always_comb begin
        state_next      = state;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_rdata       = '0;
        rsp_err         = 1'b0;
        dmem_MemRead    = 1'b0;
        dmem_MemWrite   = 1'b0;
        dmem_Write_data = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                state_next = ST_RESP;
                if (!err_q) begin
                    if (load_q) begin
                        dmem_MemRead = 1'b1;
                    end else if (store_q) begin
                        if (size_q == SZ_WORD) begin
                            dmem_MemWrite   = 1'b1;
                            dmem_Write_data = wdata_q;
                        end else begin
                            dmem_MemRead = 1'b1;
                            state_next   = ST_WRITE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                dmem_MemWrite   = 1'b1;
                dmem_Write_data = merge_q;
                state_next      = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid  = 1'b1;
                rsp_rdata  = rdata_q;
                rsp_err    = err_q;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign dmem_Address = addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 256x32 data memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_load = 1'b0;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dmem_MemRead;
    logic        dmem_MemWrite;
    logic [31:0] dmem_Address;
    logic [31:0] dmem_Write_data;
    logic [31:0] dmem_Read_data;

    logic [31:0] mem [256];

    int checks = 0;
    int passes = 0;

    mem_access_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_load        (req_load),
        .req_store       (req_store),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .dmem_MemRead    (dmem_MemRead),
        .dmem_MemWrite   (dmem_MemWrite),
        .dmem_Address    (dmem_Address),
        .dmem_Write_data (dmem_Write_data),
        .dmem_Read_data  (dmem_Read_data)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 32'h0;
    end

    assign dmem_Read_data = dmem_MemRead ? mem[dmem_Address[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (dmem_MemWrite)
            mem[dmem_Address[9:2]] <= dmem_Write_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    endtask

    // Presents one request while idle and returns #1 after its accept edge.
    task automatic applyStimulus(input logic ld, input logic st, input logic [1:0] sz,
                                 input logic un, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_load = ld; req_store = st; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        #1;
        checkOutput("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic doRequest(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                             input logic un, input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output logic [31:0] rd, output logic er,
                             output int rd_cnt, output int wr_cnt, output int wr_lat,
                             output logic [31:0] wr_data);
        lat = 0; rd = '0; er = 1'b0; rd_cnt = 0; wr_cnt = 0; wr_lat = 0; wr_data = '0;
        applyStimulus(ld, st, sz, un, a, wd);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (dmem_MemRead) rd_cnt++;
            if (dmem_MemWrite) begin
                wr_cnt++;
                wr_lat  = lat;
                wr_data = dmem_Write_data;
            end
            if (rsp_valid) begin
                rd = rsp_rdata;
                er = rsp_err;
                break;
            end
        end
        if (!rsp_valid)
            $display("[TB] no response seen for %s", tag);
    endtask

    int          lat, rd_cnt, wr_cnt, wr_lat;
    logic [31:0] rd, wr_data;
    logic        er;

    logic        e_ld [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic        e_st [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  e_sz [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] e_ad [4] = '{32'h13, 32'h12, 32'h10, 32'h10};

    logic [1:0]  p_sz [4] = '{2'b10, 2'b00, 2'b01, 2'b00};
    logic        p_un [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] p_ad [4] = '{32'h10, 32'h10, 32'h10, 32'h13};
    logic [31:0] p_ex [4] = '{32'h1234AABB, 32'h000000BB, 32'hFFFFAABB, 32'h00000012};

    initial begin
        int k, cyc, nrsp, ready_bad;
        int          rsp_cyc [4];
        logic [31:0] rsp_dat [4];
        logic        accept_now;

        #12;
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("reset_memread", {31'b0, dmem_MemRead}, 32'd0);
        checkOutput("reset_memwrite", {31'b0, dmem_MemWrite}, 32'd0);
        checkOutput("reset_address", dmem_Address, 32'h0);
        checkOutput("reset_write_data", dmem_Write_data, 32'h0);
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        doRequest("sw", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, lat, rd, er, rd_cnt, wr_cnt, wr_lat, wr_data);
        checkOutput("sw_latency", lat, 32'd2);
        checkOutput("sw_write_count", wr_cnt, 32'd1);
        checkOutput("sw_write_data", wr_data, 32'h8899AABB);
        checkOutput("sw_rdata", rd, 32'h0);
        checkOutput("sw_err", {31'b0, er}, 32'd0);

        doRequest("lw", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, rd_cnt, wr_cnt, wr_lat, wr_data);
        checkOutput("lw_latency", lat, 32'd2);
        checkOutput("lw_rdata", rd, 32'h8899AABB);
        checkOutput("lw_err", {31'b0, er}, 32'd0);

        doRequest("lb", 1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rd, er, rd_cnt, wr_cnt, wr_lat, wr_data);
        checkOutput("lb_rdata", rd, 32'hFFFFFFAA);
        doRequest("lbu", 1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rd, er, rd_cnt, wr_cnt, wr_lat, wr_data);
        checkOutput("lbu_rdata", rd, 32'h000000AA);
        doRequest("lh", 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er, rd_cnt, wr_cnt, wr_lat, wr_data);
        checkOutput("lh_rdata", rd, 32'hFFFF8899);
        doRequest("lhu", 1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er, rd_cnt, wr_cnt, wr_lat, wr_data);
        checkOutput("lhu_rdata", rd, 32'h00008899);

        doRequest("sh", 1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hDEAD1234, lat, rd, er, rd_cnt, wr_cnt, wr_lat, wr_data);
        checkOutput("sh_latency", lat, 32'd3);
        checkOutput("sh_write_count", wr_cnt, 32'd1);
        checkOutput("sh_write_cycle", wr_lat, 32'd2);
        checkOutput("sh_write_data", wr_data, 32'h1234AABB);
        checkOutput("sh_read_count", rd_cnt, 32'd1);
        checkOutput("sh_rdata", rd, 32'h0);
        doRequest("lw_after_sh", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, rd_cnt, wr_cnt, wr_lat, wr_data);
        checkOutput("lw_after_sh_rdata", rd, 32'h1234AABB);

        for (int i = 0; i < 4; i++) begin
            doRequest("err", e_ld[i], e_st[i], e_sz[i], 1'b0, e_ad[i], 32'hFFFFFFFF, lat, rd, er, rd_cnt, wr_cnt, wr_lat, wr_data);
            checkOutput($sformatf("err%0d_flag", i), {31'b0, er}, 32'd1);
            checkOutput($sformatf("err%0d_rdata", i), rd, 32'h0);
            checkOutput($sformatf("err%0d_strobes", i), rd_cnt + wr_cnt, 32'd0);
            checkOutput($sformatf("err%0d_latency", i), lat, 32'd2);
        end

        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h55);
        @(negedge clk);
        checkOutput("sb_access_read", {31'b0, dmem_MemRead}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("sb_write_strobe", {31'b0, dmem_MemWrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("sb_reset_write_drop", {31'b0, dmem_MemWrite}, 32'd0);
        checkOutput("sb_reset_idle", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("sb_reset_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("sb_release_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        doRequest("lw_after_reset", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, rd_cnt, wr_cnt, wr_lat, wr_data);
        checkOutput("lw_after_reset_rdata", rd, 32'h1234AABB);

        k = 0; cyc = 0; nrsp = 0; ready_bad = 0;
        @(negedge clk);
        req_load = 1'b1; req_store = 1'b0; req_size = p_sz[0]; req_unsigned = p_un[0];
        req_addr = p_ad[0]; req_wdata = 32'h0; req_valid = 1'b1;
        while (nrsp < 4 && cyc < 30) begin
            #1;
            cyc++;
            if (rsp_valid) begin
                rsp_cyc[nrsp] = cyc;
                rsp_dat[nrsp] = rsp_rdata;
                nrsp++;
                if (req_ready) ready_bad++;
            end
            accept_now = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (accept_now) begin
                k++;
                if (k < 4) begin
                    req_size = p_sz[k]; req_unsigned = p_un[k]; req_addr = p_ad[k];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("stream_rsp_count", nrsp, 32'd4);
        checkOutput("stream_accept_count", k, 32'd4);
        checkOutput("stream_ready_in_resp", ready_bad, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i < nrsp) begin
                checkOutput($sformatf("stream_data%0d", i), rsp_dat[i], p_ex[i]);
                if (i > 0)
                    checkOutput($sformatf("stream_gap%0d", i), rsp_cyc[i] - rsp_cyc[i-1], 32'd3);
            end
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit sitting directly upstream of the word-addressed data memory (256 x 32, word index = address[9:2], combinational read gated by MemRead, write on posedge clk when MemWrite).
- Accepts memory requests from the execute/EX-MEM stage and drives the data memory.
- Adds byte/halfword loads with sign or zero extension, and sub-word stores via read-modify-write (the memory writes whole words only).
- Adds alignment checking, and returns a registered response toward writeback.

Parameters:
- ADDR_W, 32, request/memory address width
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_load  in  1  request is a load
- req_store  in  1  request is a store
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores, errors and no-ops
- rsp_err  out  1  misaligned or illegal request, valid with rsp_valid
- dmem_MemRead  out  1  to data memory
- dmem_MemWrite  out  1  to data memory
- dmem_Address  out  32  to data memory (registered address)
- dmem_Write_data  out  32  to data memory
- dmem_Read_data  in  32  from data memory

Behaviour:
- **Clock and reset.** One clock (clk); reset rst_n is asynchronous and active-low.
- **Reset values.**
  - state = IDLE; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - dmem_MemRead = dmem_MemWrite = 0; dmem_Address = 0, dmem_Write_data = 0; all internal registers = 0.
- **States:** IDLE, ACCESS, WRITE, RESP.
- **IDLE.**
  - req_ready = 1.
  - On req_valid: capture load, store, size, unsigned, addr and wdata, then go to ACCESS.
- **Error decode (at capture).** err is set when:
  - size = 11, or
  - load and store are both 1, or
  - half with addr[0] = 1, or
  - word with addr[1:0] != 00.
- **ACCESS.**
  - dmem_Address = addr_q.
  - err_q: both strobes 0, go to RESP.
  - Load: MemRead = 1. Latch the extracted lane of dmem_Read_data into rdata_q, then go to RESP.
  - Word store: MemWrite = 1, Write_data = wdata_q, then go to RESP.
  - Sub-word store: MemRead = 1. Latch merged word into merge_q, then go to WRITE.
  - Neither load nor store: no access, go to RESP.
- **WRITE.** MemWrite = 1, Write_data = merge_q, then go to RESP.
- **RESP.** rsp_valid = 1 for exactly one cycle, with rsp_rdata and rsp_err; then go to IDLE.
- **Latency** (accept edge counts as cycle 0, rsp_valid high in cycle N):
  - Load, word store, error, no-op: N = 2.
  - Sub-word store: N = 3.
  - Throughput: at most one request per 3 (or 4) cycles; req_ready is low outside IDLE.
- **Lane rules (little-endian).**
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Loads: extract the lane, then sign-extend from bit 7 or bit 15 unless unsigned; words pass through.
  - Stores: replace only the target lane of the old word with wdata[7:0] or wdata[15:0].
- **Strobe timing.** dmem strobes are decoded from registered state only; there are no combinational paths from req_* to dmem_*.
- **Addressing.** No range check; addresses at or above 1024 alias, as in the memory.
- **Reset mid-operation.**
  - Strobes drop immediately.
  - A sub-word store reset in ACCESS or WRITE leaves memory unchanged.
  - No response is issued for the aborted request.

Decomposition:
- **Package mau_pkg:**
  - Size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - State encoding for IDLE, ACCESS, WRITE, RESP.
- **Sub-module mau_lane_align:** purely combinational, holding the load extract/extend and store merge logic; instantiated once.

Test Plan:
1. sw addr 0x10, wdata 0x8899AABB, then lw 0x10 -> rsp_rdata = 0x8899AABB, err = 0, rsp_valid 2 cycles after accept.
2. lb 0x11 -> 0xFFFFFFAA; lbu 0x11 -> 0x000000AA; lh 0x12 -> 0xFFFF8899; lhu 0x12 -> 0x00008899.
3. sh 0x12, wdata 0xDEAD1234 -> MemWrite high exactly in WRITE with Write_data = 0x1234AABB; lw 0x10 -> 0x1234AABB; rsp_valid for the store 3 cycles after accept.
4. lh 0x13, lw 0x12, size = 11, load and store both set -> each gives rsp_err = 1, rsp_rdata = 0, and MemRead/MemWrite never asserted.
5. sb 0x10, wdata 0x55, with rst_n pulled low while in WRITE -> MemWrite drops asynchronously, no rsp_valid, state IDLE; after reset release, lw 0x10 returns the pre-store value.
6. req_valid held high continuously with 4 loads -> req_ready high only in IDLE, 4 rsp_valid pulses spaced 3 cycles apart, no request lost or duplicated.
